// File: rtl/vec256_exec_if.sv
// vec256_exec_if: issue/write-back bundle between the vector issue logic and vec256_exec.
//   master (issuer) drives : start, op[2:0], sew[1:0], rs1[255:0], rs2[255:0], rd_in[4:0]
//   slave  (exec)   drives : busy, we, a3[4:0], wb[255:0], err
interface vec256_exec_if;
    logic         start;
    logic [2:0]   op;
    logic [1:0]   sew;
    logic [255:0] rs1;
    logic [255:0] rs2;
    logic [4:0]   rd_in;
    logic         busy;
    logic         we;
    logic [4:0]   a3;
    logic [255:0] wb;
    logic         err;

    modport master (
        output start, op, sew, rs1, rs2, rd_in,
        input  busy, we, a3, wb, err
    );

    modport slave (
        input  start, op, sew, rs1, rs2, rd_in,
        output busy, we, a3, wb, err
    );
endinterface

// File: rtl/vec256_exec.sv
// vec256_exec: multi-beat 256-bit SIMD execute stage.
//   Operands are latched on an accepted start, then CHUNK_W bits are computed per cycle
//   (lowest chunk first) into the WB staging register; a one-cycle WE pulse with A3 follows.
//   Ops: ADD, SUB, AND, OR, XOR, MINU, MAXU per element at SEW (8/16/32, 11 -> 32),
//   plus ADDSAT (unsigned saturating add) on OP=111 when VEC_SAT_EN is defined.
//   Without VEC_SAT_EN, OP=111 is illegal: ERR pulses for one cycle and nothing is written.
// Ports:
//   i_clk   : clock, all state on its rising edge
//   i_rst_n : asynchronous active-low reset
//   io_vec  : vec256_exec_if.slave (start/op/sew/rs1/rs2/rd_in in; busy/we/a3/wb/err out)
// Parameter CHUNK_W: bits per beat, 32/64/128/256.
module vec256_exec #(
    parameter int unsigned CHUNK_W = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    vec256_exec_if.slave  io_vec
);
    localparam int unsigned BEATS = 256 / CHUNK_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LANES = CHUNK_W / 32;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [255:0]       r_rs1;
    logic [255:0]       r_rs2;
    logic [2:0]         r_op;
    logic [1:0]         r_sew;
    logic [4:0]         r_rd;
    logic               r_busy;
    logic               r_we;
    logic               r_err;
    logic [4:0]         r_a3;
    logic [255:0]       r_wb;

    logic               w_illegal;
    int unsigned        w_base;
    logic [CHUNK_W-1:0] w_a;
    logic [CHUNK_W-1:0] w_b;
    logic [CHUNK_W-1:0] w_res;

    // One element of the given width; a/b arrive zero-extended, the result is masked to width.
    function automatic logic [31:0] elem_op(input logic [2:0] op, input int unsigned width,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] r;
`ifdef VEC_SAT_EN
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`endif
        mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = (a < b) ? a : b;
            3'b110:  r = (a > b) ? a : b;
`ifdef VEC_SAT_EN
            // Carry out of the element means overflow -> saturate to all-ones.
            3'b111:  r = sum[width] ? mask : sum[31:0];
`endif
            default: r = '0;
        endcase
        return r & mask;
    endfunction

    // One 32-bit lane split into elements; nothing propagates between elements.
    function automatic logic [31:0] lane_op(input logic [2:0] op, input logic [1:0] sew,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        case (sew)
            2'b00: begin
                for (int i = 0; i < 4; i++) begin
                    t = elem_op(op, 8, {24'd0, a[8*i +: 8]}, {24'd0, b[8*i +: 8]});
                    r[8*i +: 8] = t[7:0];
                end
            end
            2'b01: begin
                for (int i = 0; i < 2; i++) begin
                    t = elem_op(op, 16, {16'd0, a[16*i +: 16]}, {16'd0, b[16*i +: 16]});
                    r[16*i +: 16] = t[15:0];
                end
            end
            default: r = elem_op(op, 32, a, b);
        endcase
        return r;
    endfunction

`ifdef VEC_SAT_EN
    assign w_illegal = 1'b0;
`else
    assign w_illegal = (io_vec.op == 3'b111);
`endif

    assign w_base = 32'(r_cnt) * CHUNK_W;
    assign w_a    = r_rs1[w_base +: CHUNK_W];
    assign w_b    = r_rs2[w_base +: CHUNK_W];

    always_comb begin
        w_res = '0;
        for (int l = 0; l < LANES; l++) begin
            w_res[32*l +: 32] = lane_op(r_op, r_sew, w_a[32*l +: 32], w_b[32*l +: 32]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_op    <= '0;
            r_sew   <= '0;
            r_rd    <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_a3    <= '0;
            r_wb    <= '0;
        end else begin
            // WE and ERR are single-cycle pulses.
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                StIdle, StWrite: begin
                    r_state <= StIdle;
                    if (io_vec.start) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_rs1   <= io_vec.rs1;
                            r_rs2   <= io_vec.rs2;
                            r_op    <= io_vec.op;
                            r_sew   <= io_vec.sew;
                            r_rd    <= io_vec.rd_in;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= StExec;
                        end
                    end
                end
                StExec: begin
                    r_wb[w_base +: CHUNK_W] <= w_res;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= StWrite;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b1;
                        r_a3    <= r_rd;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_vec.busy = r_busy;
    assign io_vec.we   = r_we;
    assign io_vec.a3   = r_a3;
    assign io_vec.wb   = r_wb;
    assign io_vec.err  = r_err;
endmodule

// File: tb/tb_vec256_exec.sv
// tb_vec256_exec: drives identical stimulus into four vec256_exec instances
// (CHUNK_W = 32, 64, 128, 256) and checks results, latency and control pulses.
module tb_vec256_exec;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [1:0]   sew;
    logic [255:0] rs1;
    logic [255:0] rs2;
    logic [4:0]   rd_in;

    logic [3:0]   we_v;
    logic [3:0]   busy_v;
    logic [3:0]   err_v;
    logic [255:0] wb_v [4];
    logic [4:0]   a3_v [4];

    int n_checks = 0;
    int n_errs   = 0;
    int beats [4] = '{8, 4, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        vec256_exec_if u_if ();
        assign u_if.start = start;
        assign u_if.op    = op;
        assign u_if.sew   = sew;
        assign u_if.rs1   = rs1;
        assign u_if.rs2   = rs2;
        assign u_if.rd_in = rd_in;
        assign we_v[g]    = u_if.we;
        assign busy_v[g]  = u_if.busy;
        assign err_v[g]   = u_if.err;
        assign wb_v[g]    = u_if.wb;
        assign a3_v[g]    = u_if.a3;
        vec256_exec #(.CHUNK_W(32 << g)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .io_vec  (u_if)
        );
    end

    typedef struct {
        logic [2:0]   op;
        logic [1:0]   sew;
        logic [255:0] a;
        logic [255:0] b;
        logic [4:0]   rd;
        logic [255:0] exp;
        bit           err;
    } vec_t;

    vec_t tbl [9];

    int           we_cnt [4];
    int           err_cnt [4];
    int           busy_cnt [4];
    int           both [4];
    int           first [4];
    int           second [4];
    logic         busy0 [4];
    logic         err0 [4];
    logic [255:0] cap_wb [4];
    logic [255:0] cap_wb2 [4];
    logic [4:0]   cap_a3 [4];

    task automatic check(input string name, input int d, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s dut%0d: got %h want %h", name, d, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with start held for 'hold' edges, then observe a fixed window.
    task automatic issue(input vec_t v, input int hold);
        for (int d = 0; d < 4; d++) begin
            we_cnt[d] = 0; err_cnt[d] = 0; busy_cnt[d] = 0; both[d] = 0;
            first[d] = -1; second[d] = -1;
        end
        op = v.op; sew = v.sew; rs1 = v.a; rs2 = v.b; rd_in = v.rd;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 1) begin
                rs1 = ~v.a;  // operands must already be latched
                rs2 = ~v.b;
            end
            for (int d = 0; d < 4; d++) begin
                if (k == 0) begin
                    busy0[d] = busy_v[d];
                    err0[d]  = err_v[d];
                end
                if (we_v[d] && busy_v[d]) both[d]++;
                if (busy_v[d]) busy_cnt[d]++;
                if (err_v[d]) err_cnt[d]++;
                if (we_v[d]) begin
                    we_cnt[d]++;
                    if (first[d] < 0) begin
                        first[d]  = k;
                        cap_wb[d] = wb_v[d];
                        cap_a3[d] = a3_v[d];
                    end else if (second[d] < 0) begin
                        second[d]  = k;
                        cap_wb2[d] = wb_v[d];
                    end
                end
            end
            if (k + 1 >= hold) start = 1'b0;
            if (k == 1) begin
                rs1 = v.a;
                rs2 = v.b;
            end
        end
    endtask

    task automatic check_normal(input vec_t v, input string name);
        for (int d = 0; d < 4; d++) begin
            check({name, " we_count"}, d, we_cnt[d], 1);
            check({name, " latency"}, d, first[d], beats[d]);
            check({name, " wb"}, d, cap_wb[d], v.exp);
            check({name, " a3"}, d, cap_a3[d], v.rd);
            check({name, " busy_at_start"}, d, busy0[d], 1'b1);
            check({name, " busy_cycles"}, d, busy_cnt[d], beats[d]);
            check({name, " we_and_busy"}, d, both[d], 0);
            check({name, " err_count"}, d, err_cnt[d], 0);
        end
    endtask

    task automatic check_err(input string name);
        for (int d = 0; d < 4; d++) begin
            check({name, " err_pulse"}, d, err0[d], 1'b1);
            check({name, " err_count"}, d, err_cnt[d], 1);
            check({name, " we_count"}, d, we_cnt[d], 0);
            check({name, " busy_cycles"}, d, busy_cnt[d], 0);
        end
    endtask

    initial begin
        vec_t v;
        int   n_we;

        tbl[0] = '{3'b000, 2'b00, {32{8'hFF}}, {32{8'h01}}, 5'd3, 256'h0, 1'b0};
        tbl[1] = '{3'b001, 2'b10, 256'h0, {8{32'h1}}, 5'd7, {8{32'hFFFF_FFFF}}, 1'b0};
        tbl[2] = '{3'b110, 2'b01, {16{16'h8000}}, {16{16'h7FFF}}, 5'd9, {16{16'h8000}}, 1'b0};
        tbl[3] = '{3'b100, 2'b01, {8{32'hA5A5_0F0F}}, {8{32'hFFFF_0000}}, 5'd1,
                   {8{32'h5A5A_0F0F}}, 1'b0};
        tbl[4] = '{3'b101, 2'b10, {8{32'h8000_0001}}, {8{32'h7FFF_FFFF}}, 5'd30,
                   {8{32'h7FFF_FFFF}}, 1'b0};
        tbl[5] = '{3'b000, 2'b01, {16{16'hFFFF}}, {16{16'h0002}}, 5'd12, {16{16'h0001}}, 1'b0};
        tbl[6] = '{3'b011, 2'b00, {32{8'h0F}}, {32{8'h30}}, 5'd31, {32{8'h3F}}, 1'b0};
        tbl[7] = '{3'b000, 2'b10,
                   256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000,
                   256'h00000070_00000060_00000050_00000040_00000030_00000020_00000010_00000000,
                   5'd17,
                   256'h00000077_00000066_00000055_00000044_00000033_00000022_00000011_00000000,
                   1'b0};
`ifdef VEC_SAT_EN
        tbl[8] = '{3'b111, 2'b00, {32{8'hF0}}, {32{8'h20}}, 5'd5, {32{8'hFF}}, 1'b0};
`else
        tbl[8] = '{3'b111, 2'b00, {32{8'hF0}}, {32{8'h20}}, 5'd5, 256'h0, 1'b1};
`endif

        rst_n = 1'b0; start = 1'b0; op = '0; sew = '0; rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (3) step();
        for (int d = 0; d < 4; d++) begin
            check("reset busy", d, busy_v[d], 1'b0);
            check("reset we", d, we_v[d], 1'b0);
            check("reset err", d, err_v[d], 1'b0);
            check("reset a3", d, a3_v[d], 5'd0);
            check("reset wb", d, wb_v[d], 256'h0);
        end
        rst_n = 1'b1;
        step();

        // Asynchronous reset two beats into EXEC discards the op.
        op = 3'b000; sew = 2'b00; rs1 = {32{8'h11}}; rs2 = {32{8'h22}}; rd_in = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            check("midreset busy", d, busy_v[d], 1'b0);
            check("midreset we", d, we_v[d], 1'b0);
            check("midreset wb", d, wb_v[d], 256'h0);
            check("midreset a3", d, a3_v[d], 5'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 4; d++) we_cnt[d] = 0;
        repeat (15) begin
            step();
            for (int d = 0; d < 4; d++) if (we_v[d]) we_cnt[d]++;
        end
        for (int d = 0; d < 4; d++) check("midreset no_we", d, we_cnt[d], 0);

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i], 1);
            if (tbl[i].err) check_err($sformatf("vec%0d", i));
            else check_normal(tbl[i], $sformatf("vec%0d", i));
        end

        // START held into EXEC is ignored: exactly one write.
        issue(tbl[1], 2);
        check_normal(tbl[1], "busy_start");

        // START held through WRITE: back-to-back ops, one every BEATS+1 cycles.
        v = tbl[2];
        issue(v, 25);
        for (int d = 0; d < 4; d++) begin
            check("b2b first", d, first[d], beats[d]);
            check("b2b spacing", d, second[d] - first[d], beats[d] + 1);
            check("b2b wb1", d, cap_wb[d], v.exp);
            check("b2b wb2", d, cap_wb2[d], v.exp);
            check("b2b we_and_busy", d, both[d], 0);
        end

        // After the stream drains, WB still holds the last result.
        n_we = 0;
        for (int d = 0; d < 4; d++) if (we_v[d]) n_we++;
        check("drain we_idle", 0, n_we, 0);
        for (int d = 0; d < 4; d++) check("wb_hold", d, wb_v[d], v.exp);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
